// File: rtl/nx_indirect_mem_arb.sv
// nx_indirect_mem_arb
//   Shares one single-port table RAM between the hardware datapath port (hw_*)
//   and the software indirect-access controller port (sw_*). One access per
//   clock; read data returns a fixed RD_LATENCY+1 cycles after the grant and is
//   tagged to its owner. HW wins by default; a bounded starvation counter and
//   the controller's yield force SW service.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   hw_req/hw_we/hw_add/hw_wdat    HW request (held until hw_gnt)
//   hw_gnt, hw_rvld                HW accepted this cycle / HW read data on rdat
//   sw_cs/sw_we/sw_add/sw_wdat     controller request (held until grant)
//   yield                          controller timer half-expired, forces SW
//   grant, rsp                     SW accepted this cycle / SW read data on rdat
//   rdat                           read data (mem_rdat passed through)
//   mem_cs/mem_we/mem_add/mem_wdat registered RAM command
//   mem_rdat                       RAM read data
module nx_indirect_mem_arb #(
  parameter int N_ADDR_BITS  = 14,
  parameter int N_DATA_BITS  = 38,
  parameter int RD_LATENCY   = 1,
  parameter int MAX_HW_BURST = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hw_req,
  input  logic                   hw_we,
  input  logic [N_ADDR_BITS-1:0] hw_add,
  input  logic [N_DATA_BITS-1:0] hw_wdat,
  output logic                   hw_gnt,
  output logic                   hw_rvld,
  input  logic                   sw_cs,
  input  logic                   sw_we,
  input  logic [N_ADDR_BITS-1:0] sw_add,
  input  logic [N_DATA_BITS-1:0] sw_wdat,
  input  logic                   yield,
  output logic                   grant,
  output logic                   rsp,
  output logic [N_DATA_BITS-1:0] rdat,
  output logic                   mem_cs,
  output logic                   mem_we,
  output logic [N_ADDR_BITS-1:0] mem_add,
  output logic [N_DATA_BITS-1:0] mem_wdat,
  input  logic [N_DATA_BITS-1:0] mem_rdat
);

  localparam logic [7:0] STARVE_MAX = 8'(MAX_HW_BURST);

  typedef enum logic {HW_PRI = 1'b0, SW_PRI = 1'b1} pri_t;

  pri_t       pri_r;
  logic [7:0] starve_r;
  logic [7:0] starve_nxt;
  logic       sw_win;
  logic       hw_win;
  logic       rd_push;

  // Tag pipe: bit k holds the read issued k+1 cycles ago.
  logic [RD_LATENCY:0] tag_vld_p;
  logic [RD_LATENCY:0] tag_sw_p;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= STARVE_MAX) ? v : v + 8'd1;
  endfunction

  // Arbitration: a same-cycle yield overrides HW even before pri_r flips.
  always_comb begin
    sw_win = sw_cs && (!hw_req || (pri_r == SW_PRI) || yield);
    hw_win = hw_req && !sw_win;
  end

  assign grant  = sw_win;
  assign hw_gnt = hw_win;

  always_comb begin
    starve_nxt = starve_r;
    if (!sw_cs || sw_win)
      starve_nxt = 8'd0;
    else if (hw_win)
      starve_nxt = sat_inc(starve_r);
  end

  // Flipping on the grant that reaches the limit lets SW win the very next
  // cycle, so HW gets at most MAX_HW_BURST consecutive grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_r    <= HW_PRI;
      starve_r <= 8'd0;
    end else begin
      starve_r <= starve_nxt;
      case (pri_r)
        HW_PRI:
          if (sw_cs && !sw_win && (yield || starve_nxt == STARVE_MAX))
            pri_r <= SW_PRI;
        SW_PRI:
          if (sw_win)
            pri_r <= HW_PRI;
        default: pri_r <= HW_PRI;
      endcase
    end
  end

  // ---- p0: register the winning command onto the RAM port ----
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_add  <= '0;
      mem_wdat <= '0;
    end else if (sw_win) begin
      mem_cs   <= 1'b1;
      mem_we   <= sw_we;
      mem_add  <= sw_add;
      mem_wdat <= sw_wdat;
    end else if (hw_win) begin
      mem_cs   <= 1'b1;
      mem_we   <= hw_we;
      mem_add  <= hw_add;
      mem_wdat <= hw_wdat;
    end else begin
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
    end
  end

  assign rd_push = (sw_win && !sw_we) || (hw_win && !hw_we);

  // ---- p0..pRD_LATENCY: read owner tags travel alongside the RAM latency ----
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_p <= '0;
      tag_sw_p  <= '0;
    end else begin
      tag_vld_p <= {tag_vld_p[RD_LATENCY-1:0], rd_push};
      tag_sw_p  <= {tag_sw_p[RD_LATENCY-1:0], sw_win};
    end
  end

  assign hw_rvld = tag_vld_p[RD_LATENCY] && !tag_sw_p[RD_LATENCY];
  assign rsp     = tag_vld_p[RD_LATENCY] &&  tag_sw_p[RD_LATENCY];
  assign rdat    = mem_rdat;

endmodule

// File: tb/tb_nx_indirect_mem_arb.sv
// tb_nx_indirect_mem_arb
//   Directed bench for nx_indirect_mem_arb with default parameters
//   (RD_LATENCY=1, MAX_HW_BURST=8). A one-cycle RAM model returns a data
//   pattern derived from the read address.
module tb_nx_indirect_mem_arb;

  localparam int AW = 14;
  localparam int DW = 38;

  logic          clk = 1'b0;
  logic          rst;
  logic          hw_req, hw_we;
  logic [AW-1:0] hw_add;
  logic [DW-1:0] hw_wdat;
  logic          hw_gnt, hw_rvld;
  logic          sw_cs, sw_we;
  logic [AW-1:0] sw_add;
  logic [DW-1:0] sw_wdat;
  logic          yield;
  logic          grant, rsp;
  logic [DW-1:0] rdat;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_wdat;
  logic [DW-1:0] mem_rdat = '0;

  int n_chk = 0;
  int n_err = 0;

  nx_indirect_mem_arb dut (
    .clk(clk), .rst(rst),
    .hw_req(hw_req), .hw_we(hw_we), .hw_add(hw_add), .hw_wdat(hw_wdat),
    .hw_gnt(hw_gnt), .hw_rvld(hw_rvld),
    .sw_cs(sw_cs), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat),
    .yield(yield), .grant(grant), .rsp(rsp), .rdat(rdat),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_add(mem_add), .mem_wdat(mem_wdat),
    .mem_rdat(mem_rdat)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
    return {a, 24'hC3C3C3};
  endfunction

  // RAM model: read data valid one cycle after the command is sampled.
  always @(posedge clk)
    if (mem_cs && !mem_we) mem_rdat <= ram_val(mem_add);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hw_req = 0; hw_we = 0; hw_add = '0; hw_wdat = '0;
    sw_cs = 0; sw_we = 0; sw_add = '0; sw_wdat = '0; yield = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic sw_pend;
    logic exp_sw, exp_h, exp_s;
    int   cnt_h, cnt_s;

    rst = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_cs", mem_cs, 0);
    check("rst_mem_add", mem_add, 0);
    check("rst_pri", dut.pri_r, 0);
    check("rst_starve", dut.starve_r, 0);
    check("rst_rvld", {hw_rvld, rsp}, 0);

    // Test 1: lone SW read
    cyc(); rst = 0; sw_cs = 1; sw_we = 0; sw_add = 14'h0005;
    @(negedge clk);
    check("t1_grant", grant, 1);
    check("t1_hw_gnt", hw_gnt, 0);
    cyc(); idle();
    @(negedge clk);
    check("t1_mem_cs", mem_cs, 1);
    check("t1_mem_add", mem_add, 14'h0005);
    check("t1_mem_we", mem_we, 0);
    check("t1_rsp_early", rsp, 0);
    cyc();
    @(negedge clk);
    check("t1_rsp", rsp, 1);
    check("t1_rdat", rdat, ram_val(14'h0005));
    check("t1_hw_rvld", hw_rvld, 0);
    cyc();
    @(negedge clk);
    check("t1_rsp_pulse", rsp, 0);

    // Test 2: HW burst limited to 8 while SW waits
    sw_pend = 1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      hw_req = 1; hw_we = 1; hw_add = AW'(c); hw_wdat = DW'(c);
      sw_cs = sw_pend; sw_we = 1; sw_add = 14'h0200; yield = 0;
      @(negedge clk);
      exp_sw = (c == 8);
      check("t2_grant", grant, exp_sw);
      check("t2_hw_gnt", hw_gnt, !exp_sw);
      if (c == 8) begin
        check("t2_starve_max", dut.starve_r, 8);
        check("t2_pri_sw", dut.pri_r, 1);
      end
      if (c == 9) begin
        check("t2_starve_clr", dut.starve_r, 0);
        check("t2_pri_hw", dut.pri_r, 0);
      end
      if (grant) sw_pend = 0;
    end
    cyc(); idle();
    @(negedge clk);

    // Test 3: yield from cycle 3 forces SW immediately
    sw_pend = 1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      hw_req = 1; hw_we = 1; hw_add = AW'(c); hw_wdat = DW'(c);
      sw_cs = sw_pend; sw_we = 1; sw_add = 14'h0300;
      yield = sw_pend && (c >= 3);
      @(negedge clk);
      exp_sw = (c == 3);
      check("t3_grant", grant, exp_sw);
      check("t3_hw_gnt", hw_gnt, !exp_sw);
      if (c == 3) check("t3_starve", dut.starve_r, 3);
      if (grant) sw_pend = 0;
    end
    cyc(); idle();
    @(negedge clk);

    // Test 4: alternating HW/SW reads, owners and latency
    cnt_h = 0; cnt_s = 0;
    for (int c = 0; c < 24; c++) begin
      int g;
      cyc(); idle();
      if (c < 20) begin
        if (c % 2 == 0) begin hw_req = 1; hw_we = 0; hw_add = AW'(c); end
        else begin sw_cs = 1; sw_we = 0; sw_add = AW'(32'h100 + c); end
      end
      @(negedge clk);
      g = c - 2;
      exp_h = (g >= 0) && (g < 20) && (g % 2 == 0);
      exp_s = (g >= 0) && (g < 20) && (g % 2 == 1);
      check("t4_hw_rvld", hw_rvld, exp_h);
      check("t4_rsp", rsp, exp_s);
      if (exp_h) check("t4_hw_rdat", rdat, ram_val(AW'(g)));
      if (exp_s) check("t4_sw_rdat", rdat, ram_val(AW'(32'h100 + g)));
      cnt_h += int'(hw_rvld);
      cnt_s += int'(rsp);
    end
    check("t4_hw_count", cnt_h, 10);
    check("t4_sw_count", cnt_s, 10);

    // Test 5: SW write at top address, no response
    cyc(); idle();
    sw_cs = 1; sw_we = 1; sw_add = 14'h3FFF; sw_wdat = 38'h2A_AAAA_AAAA;
    @(negedge clk);
    check("t5_grant", grant, 1);
    cyc(); idle();
    @(negedge clk);
    check("t5_mem_cs", mem_cs, 1);
    check("t5_mem_we", mem_we, 1);
    check("t5_mem_add", mem_add, 14'h3FFF);
    check("t5_mem_wdat", mem_wdat, 38'h2A_AAAA_AAAA);
    for (int c = 0; c < 2; c++) begin
      cyc();
      @(negedge clk);
      check("t5_no_rsp", rsp, 0);
    end

    // Test 6: reset right after a SW read grant (grant won via yield)
    cyc(); idle();
    sw_cs = 1; sw_we = 0; sw_add = 14'h00AB; sw_wdat = 38'h1234;
    hw_req = 1; hw_we = 1; hw_add = 14'h0001; yield = 1;
    @(negedge clk);
    check("t6_grant", grant, 1);
    check("t6_hw_gnt", hw_gnt, 0);
    cyc(); idle(); rst = 1;
    @(negedge clk);
    check("t6_mem_add_pre", mem_add, 14'h00AB);
    cyc(); rst = 0;
    @(negedge clk);
    check("t6_rsp", rsp, 0);
    check("t6_hw_rvld", hw_rvld, 0);
    check("t6_mem_cs", mem_cs, 0);
    check("t6_mem_we", mem_we, 0);
    check("t6_mem_add", mem_add, 0);
    check("t6_mem_wdat", mem_wdat, 0);
    check("t6_pri", dut.pri_r, 0);
    check("t6_starve", dut.starve_r, 0);
    cyc();
    @(negedge clk);
    check("t6_rsp_late", rsp, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
